// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N_CH producer streams in, one registered stream out.
// With STREAM_MUX_PKT_LOCK_EN defined, in_last/out_last carry end-of-packet flags.
interface stream_mux_rr_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) ();
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;
    logic                  out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [N_CH-1:0]       in_last;
    logic                  out_last;
`endif

    // master: producers + consumer side (drives the mux)
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
        output in_last,
        input  out_last,
`endif
        input  in_ready, out_data, out_ch, out_valid
    );

    // slave: the mux itself
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
        input  in_last,
        output out_last,
`endif
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel streaming mux with one-entry registered output; fixed-select or round-robin grant.
// Optional packet locking under STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            reset,
    stream_mux_rr_if.slave bus
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH-1:0][WIDTH-1:0] ch_data;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic             out_last_q, out_last_d;
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
`endif

    logic             load_en;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_ch;
    logic             xfer;
    logic             last_beat;
    logic [N_CH-1:0]  in_ready;

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    assign load_en = !out_valid_q || bus.out_ready;

    always_comb begin
        logic [SEL_W-1:0] idx;
        grant_valid = 1'b0;
        grant_ch    = '0;
        idx         = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_q) begin
            // mid-packet: only the owning channel may proceed, even if it is idle
            grant_ch    = lock_ch_q;
            grant_valid = bus.in_valid[lock_ch_q];
        end else
`endif
        if (!bus.mode) begin
            if (int'(bus.sel) < N_CH) begin
                grant_ch    = bus.sel;
                grant_valid = bus.in_valid[bus.sel];
            end
        end else begin
            for (int k = 1; k <= N_CH; k++) begin
                idx = SEL_W'((int'(rr_ptr_q) + k) % N_CH);
                if (!grant_valid && bus.in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_ch    = idx;
                end
            end
        end
    end

    assign xfer = !reset && load_en && grant_valid;

`ifdef STREAM_MUX_PKT_LOCK_EN
    assign last_beat = bus.in_last[grant_ch];
`else
    assign last_beat = 1'b1;
`endif

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[grant_ch] = 1'b1;
    end
    assign bus.in_ready = in_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
        out_last_d  = out_last_q;
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (xfer) begin
            out_data_d  = ch_data[grant_ch];
            out_ch_d    = grant_ch;
            out_valid_d = 1'b1;
            // pointer only moves at packet boundaries so a locked packet keeps its turn
            if (bus.mode && last_beat) rr_ptr_d = grant_ch;
`ifdef STREAM_MUX_PKT_LOCK_EN
            out_last_d  = last_beat;
            lock_d      = !last_beat;
            lock_ch_d   = grant_ch;
`endif
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SEL_W'(N_CH - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
            out_last_q  <= 1'b0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
            out_last_q  <= out_last_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
    assign bus.out_last  = out_last_q;
`endif
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: stimulus pushes expected beats, a negedge monitor pops and compares.
// Packet-lock scenarios run only when STREAM_MUX_PKT_LOCK_EN is defined.
module tb_stream_mux_rr;
    localparam int N_CH  = 4;
    localparam int WIDTH = 8;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    stream_mux_rr_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

    stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic [7:0] data, input logic last);
        beat_t b;
        b.ch = ch; b.data = data; b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic set_ch(input int ch, input logic [7:0] d);
        bus.in_data[ch*WIDTH +: WIDTH] = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a beat is consumed at the next posedge whenever valid && ready at negedge
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got ch %0d data %0h expected none", bus.out_ch, bus.out_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_ch", 32'(bus.out_ch), 32'(e.ch));
                chk("beat_data", 32'(bus.out_data), 32'(e.data));
`ifdef STREAM_MUX_PKT_LOCK_EN
                chk("beat_last", 32'(bus.out_last), 32'(e.last));
`endif
            end
        end
    end

    initial begin
        beat_t dropped;
        bus.in_data   = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        bus.in_valid  = 4'hF;
        bus.mode      = 1'b1;
        bus.sel       = 2'd0;
        bus.out_ready = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
        bus.in_last   = 4'hF;
`endif
        // reset held 2 cycles with everything valid
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // round-robin fairness, one beat per cycle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_in_ready", 32'(bus.in_ready), 32'(1 << (i % 4)));
            push(2'(i % 4), 8'hC0 + 8'(i % 4), 1'b1);
            nxt();
        end
        bus.in_valid = 4'h0;
        @(negedge clk);
        chk("rr_idle_ready", 32'(bus.in_ready), 0);
        nxt();
        @(negedge clk);
        chk("rr_drained", 32'(bus.out_valid), 0);
        nxt();

        // fixed mode, sel=2
        bus.mode = 1'b0;
        bus.sel = 2'd2;
        set_ch(2, 8'hA5);
        bus.in_valid = 4'b0100;
        @(negedge clk);
        chk("fix_in_ready", 32'(bus.in_ready), 32'b0100);
        push(2'd2, 8'hA5, 1'b1);
        nxt();
        bus.in_valid = 4'b1011;
        @(negedge clk);
        chk("fix_unsel_ready", 32'(bus.in_ready), 0);
        nxt();
        @(negedge clk);
        chk("fix_drop_valid", 32'(bus.out_valid), 0);
        chk("fix_hold_data", 32'(bus.out_data), 32'hA5);
        chk("fix_hold_ch", 32'(bus.out_ch), 2);
        nxt();

        // backpressure for 3 cycles, then drain+load in one cycle
        bus.sel = 2'd1;
        set_ch(1, 8'h3C);
        bus.in_valid = 4'b0010;
        @(negedge clk);
        chk("bp_in_ready", 32'(bus.in_ready), 32'b0010);
        push(2'd1, 8'h3C, 1'b1);
        nxt();
        bus.out_ready = 1'b0;
        set_ch(1, 8'h4D);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall_ready", 32'(bus.in_ready), 0);
            chk("bp_stall_data", 32'(bus.out_data), 32'h3C);
            nxt();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.in_ready), 32'b0010);
        push(2'd1, 8'h4D, 1'b1);
        nxt();
        bus.in_valid = 4'h0;
        @(negedge clk);
        chk("bp_no_bubble_valid", 32'(bus.out_valid), 1);
        chk("bp_no_bubble_data", 32'(bus.out_data), 32'h4D);
        nxt();
        @(negedge clk);
        chk("bp_drained", 32'(bus.out_valid), 0);
        nxt();

        // reset mid-stream: rr_ptr is 1, so ch2 wins, then reset drops the held beat
        bus.mode = 1'b1;
        bus.in_valid = 4'b0100;
        @(negedge clk);
        chk("mrst_in_ready", 32'(bus.in_ready), 32'b0100);
        push(2'd2, 8'hA5, 1'b1);
        nxt();
        bus.out_ready = 1'b0;
        bus.in_valid = 4'h0;
        @(negedge clk);
        chk("mrst_held", 32'(bus.out_valid), 1);
        nxt();
        reset = 1'b1;
        bus.in_valid = 4'hF;
        bus.out_ready = 1'b1;
        dropped = exp_q.pop_back();
        @(negedge clk);
        chk("mrst_ready_in_reset", 32'(bus.in_ready), 0);
        nxt();
        @(negedge clk);
        chk("mrst_out_valid", 32'(bus.out_valid), 0);
        nxt();
        reset = 1'b0;
        bus.in_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        @(negedge clk);
        chk("mrst_first_ch0", 32'(bus.in_ready), 32'b0001);
        push(2'd0, 8'hC0, 1'b1);
        nxt();
        bus.in_valid = 4'h0;
        nxt();

`ifdef STREAM_MUX_PKT_LOCK_EN
        // 3-beat packet on ch1; switch to fixed sel=0 mid-packet, lock must hold ch1
        bus.mode = 1'b1;
        bus.in_valid = 4'b0011;
        bus.in_last = 4'b0001;
        set_ch(1, 8'h51);
        @(negedge clk);
        chk("pkt_b1_ready", 32'(bus.in_ready), 32'b0010);
        push(2'd1, 8'h51, 1'b0);
        nxt();
        bus.mode = 1'b0;
        bus.sel = 2'd0;
        set_ch(1, 8'h52);
        @(negedge clk);
        chk("pkt_b2_ready", 32'(bus.in_ready), 32'b0010);
        push(2'd1, 8'h52, 1'b0);
        nxt();
        set_ch(1, 8'h53);
        bus.in_last = 4'b0011;
        @(negedge clk);
        chk("pkt_b3_ready", 32'(bus.in_ready), 32'b0010);
        push(2'd1, 8'h53, 1'b1);
        nxt();
        bus.mode = 1'b1;
        bus.in_valid = 4'b0001;
        @(negedge clk);
        chk("pkt_after_ch0", 32'(bus.in_ready), 32'b0001);
        push(2'd0, 8'hC0, 1'b1);
        nxt();
        // ch1 idle mid-packet still blocks ch0
        bus.in_valid = 4'b0011;
        bus.in_last = 4'b0001;
        set_ch(1, 8'h61);
        @(negedge clk);
        chk("pkt2_b1_ready", 32'(bus.in_ready), 32'b0010);
        push(2'd1, 8'h61, 1'b0);
        nxt();
        bus.in_valid = 4'b0001;
        @(negedge clk);
        chk("pkt2_blocked", 32'(bus.in_ready), 0);
        nxt();
        bus.in_valid = 4'b0011;
        bus.in_last = 4'b0011;
        set_ch(1, 8'h62);
        @(negedge clk);
        chk("pkt2_b2_ready", 32'(bus.in_ready), 32'b0010);
        push(2'd1, 8'h62, 1'b1);
        nxt();
        bus.in_valid = 4'b0001;
        @(negedge clk);
        chk("pkt2_unlock_ch0", 32'(bus.in_ready), 32'b0001);
        push(2'd0, 8'hC0, 1'b1);
        nxt();
        bus.in_valid = 4'h0;
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) nxt();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
